// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: 2-flop synchroniser, mid-bit sampling, one-entry valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at every sample point.
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          at_sample;
    logic          sample;
    logic          complete;
    logic          bad_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= serial_in;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        target = CW'(SYMBOL_EDGE_TIME - 1);
        if (state == START)
            target = CW'(SAMPLE_TIME - 1);
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote is decided one clock past target, so the next bit starts at 1.
    localparam logic [CW-1:0] RELOAD = CW'(1);

    logic maj_a;
    logic maj_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (cnt == target - CW'(1))
                maj_a <= rx_s;
            if (cnt == target)
                maj_b <= rx_s;
        end
    end

    assign at_sample = (cnt == target + CW'(1));
    assign sample    = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
    localparam logic [CW-1:0] RELOAD = '0;

    assign at_sample = (cnt == target);
    assign sample    = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (at_sample) begin
                        bit_idx <= '0;
                        if (sample) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= DATA;
                            cnt   <= RELOAD;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        shift[bit_idx] <= sample;
                        bit_idx        <= bit_idx + 3'd1;
                        cnt            <= RELOAD;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        cnt   <= '0;
                        state <= sample ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign complete = (state == STOP) && at_sample && sample;
    assign bad_stop = (state == STOP) && at_sample && !sample;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= bad_stop;
            overrun       <= 1'b0;
            if (complete) begin
                // A consumer taking the old byte this cycle frees the slot.
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end
endmodule
